tlb_miss_sched: RTL

TLB_MISS_SCHED -- requirements
Module: tlb_miss_sched

---
 rtl/tlb_miss_pkg.sv | 24 ++
 rtl/tlb_miss_sched_rr.sv | 33 +++
 rtl/tlb_miss_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tlb_miss_pkg.sv
// rtl/tlb_miss_pkg.sv - shared types, widths and response codes for the TLB miss scheduler
package tlb_miss_pkg;

  localparam int PfnWidth = 52;

  typedef logic [PfnWidth-1:0] pfn_t;

  typedef enum logic {
    Idle   = 1'b0,
    Locked = 1'b1
  } sched_state_e;

  typedef enum logic [1:0] {
    HandledNone       = 2'd0,
    HandledOk         = 2'd1,
    HandledNotPending = 2'd2,
    HandledBadId      = 2'd3
  } handled_resp_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_miss_sched_rr.sv
// rtl/tlb_miss_sched_rr.sv - combinational wrapping priority pick starting at the round-robin pointer
module tlb_miss_sched_rr
  import tlb_miss_pkg::*;
#(
  parameter int NumCores = 8,
  localparam int IdxW = idx_width(NumCores)
) (
  input  logic [NumCores-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  localparam logic [IdxW:0] NumW = (IdxW+1)'(NumCores);

  logic [IdxW:0] sum;

  // One extra bit lets ptr+offset be reduced modulo NumCores with a single subtract.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int off = 0; off < NumCores; off++) begin
      sum = {1'b0, ptr_i} + (IdxW+1)'(off);
      if (sum >= NumW) sum = sum - NumW;
      if (!valid_o && req_i[sum[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = sum[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/tlb_miss_sched.sv
// rtl/tlb_miss_sched.sv - round-robin TLB miss dispatcher with pending tracking
// Optional per-core miss timeout enabled by TLB_MISS_SCHED_TIMEOUT_EN.
module tlb_miss_sched
  import tlb_miss_pkg::*;
#(
  parameter int NumCores      = 8,
  parameter int TimeoutCycles = 1024,
  localparam int IdxW = idx_width(NumCores)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [IdxW-1:0]     miss_id_i,
  input  logic [NumCores-1:0] cons_req_i,
  output logic [NumCores-1:0] cons_gnt_o,
  output logic [NumCores-1:0] cons_valid_o,
  input  logic [NumCores-1:0] cons_ready_i,
  input  logic                handled_valid_i,
  input  logic [IdxW-1:0]     handled_id_i,
  output logic [NumCores-1:0] pending_o,
  output logic                err_o,
  output logic [NumCores-1:0] timeout_o
);

  typedef logic [IdxW-1:0] core_id_t;

  localparam logic [IdxW:0] NumW = (IdxW+1)'(NumCores);

  function automatic core_id_t next_idx(input core_id_t i);
    return (i == core_id_t'(NumCores-1)) ? '0 : i + core_id_t'(1);
  endfunction

  sched_state_e        state_q, state_d;
  core_id_t            ptr_q, ptr_d, lock_q, lock_d;
  logic [NumCores-1:0] pending_q, pending_d;
  logic                err_q;
  handled_resp_e       hresp;
  logic [NumCores-1:0] gnt, valid, set_vec, clr_vec, to_fire;
  logic                miss_ready;
  core_id_t            win;
  logic                win_valid;

  tlb_miss_sched_rr #(.NumCores(NumCores)) u_rr (
    .req_i   (cons_req_i),
    .ptr_i   (ptr_q),
    .idx_o   (win),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    gnt        = '0;
    valid      = '0;
    miss_ready = 1'b0;
    case (state_q)
      Idle: begin
        if (win_valid) begin
          gnt[win] = 1'b1;
          if (miss_valid_i) begin
            valid[win] = 1'b1;
            if (cons_ready_i[win]) begin
              miss_ready = 1'b1;
              ptr_d      = next_idx(win);
            end else begin
              state_d = Locked;
              lock_d  = win;
            end
          end else begin
            ptr_d = next_idx(win);
          end
        end
      end
      Locked: begin
        gnt[lock_q]   = 1'b1;
        valid[lock_q] = 1'b1;
        if (cons_ready_i[lock_q]) begin
          miss_ready = 1'b1;
          ptr_d      = next_idx(lock_q);
          state_d    = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // A handoff for the same core wins over a handled report in the same cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    hresp   = HandledNone;
    if (miss_ready && ({1'b0, miss_id_i} < NumW)) set_vec[miss_id_i] = 1'b1;
    if (handled_valid_i) begin
      if ({1'b0, handled_id_i} >= NumW) begin
        hresp = HandledBadId;
      end else if (set_vec[handled_id_i]) begin
        hresp = HandledOk;
      end else if (!pending_q[handled_id_i]) begin
        hresp = HandledNotPending;
      end else begin
        hresp = HandledOk;
        clr_vec[handled_id_i] = 1'b1;
      end
    end
  end

  assign pending_d = (pending_q & ~clr_vec & ~to_fire) | set_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      ptr_q     <= '0;
      lock_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      pending_q <= pending_d;
      err_q     <= (hresp == HandledNotPending) || (hresp == HandledBadId);
    end
  end

`ifdef TLB_MISS_SCHED_TIMEOUT_EN
  localparam int CntW = idx_width(TimeoutCycles + 1);

  logic [CntW-1:0]     cnt_q [NumCores];
  logic [NumCores-1:0] timeout_q;

  always_comb begin
    to_fire = '0;
    for (int i = 0; i < NumCores; i++) begin
      to_fire[i] = pending_q[i] && (cnt_q[i] == CntW'(TimeoutCycles - 1))
                   && !clr_vec[i] && !set_vec[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= '0;
      for (int i = 0; i < NumCores; i++) cnt_q[i] <= '0;
    end else begin
      timeout_q <= to_fire;
      for (int i = 0; i < NumCores; i++) begin
        if (set_vec[i]) cnt_q[i] <= '0;
        else if (pending_q[i]) cnt_q[i] <= cnt_q[i] + CntW'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles > 1);
  assign to_fire   = '0;
  assign timeout_o = '0;
`endif

  // Combinational handshake outputs are forced low for the whole reset window.
  assign cons_gnt_o   = rst_ni ? gnt : '0;
  assign cons_valid_o = rst_ni ? valid : '0;
  assign miss_ready_o = rst_ni & miss_ready;
  assign pending_o    = pending_q;
  assign err_o        = err_q;

endmodule
